// File: rtl/pairing_host_loader.sv
// pairing_host_loader: host front end for BN254_pairing (operand load to L3 limbs, run control, readback).
// Latency: first RAM write t+1 after accept; core_run t+1 after start; rd_valid t+2+RD_LAT after read accept.
// Backpressure: one transaction at a time, readies low outside IDLE; `PAIRING_LOADER_BCAST_EN replicates writes to every bank.
package pairing_loader_pkg;
   localparam int ADD_DIV = 4;
   typedef logic [79:0] fp_div4_t;
   typedef struct packed {
      logic [7:0] carry;
      fp_div4_t   val;
   } limb_t;
   typedef limb_t [ADD_DIV-1:0] redundant_poly_L3;
   typedef logic [ADD_DIV*$bits(fp_div4_t)-1:0] M_tilde12_t;
endpackage

module pairing_host_loader
   import pairing_loader_pkg::*;
#(
   parameter int VAL_W   = $bits(M_tilde12_t),
   parameter int N_BANK  = 4,
   parameter int RD_LAT  = 4,
   parameter int BUSY_TO = 64
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   input  logic [8:0]             wr_addr,
   input  logic [VAL_W-1:0]       wr_data,
   input  logic                   start,
   input  logic [3:0]             func,
   output logic                   done,
   output logic                   err,
   input  logic                   rd_req_valid,
   output logic                   rd_req_ready,
   input  logic [8:0]             rd_addr,
   output logic                   rd_valid,
   input  logic                   rd_ready,
   output logic [288:0]           rd_data,
   output logic                   core_extin_en,
   output logic [8:0]             core_extin_addr,
   output redundant_poly_L3       core_extin_data,
   output logic                   core_run,
   output logic                   core_swrst,
   output logic [3:0]             core_n_func,
   output logic [8:0]             core_extout_addr,
   input  logic                   core_busy,
   input  logic [288:0]           core_extout_data
);
   localparam int FW = $bits(fp_div4_t);

   typedef enum logic [2:0] {IDLE, WRITE, RUN_HI, RUN_LO, RD_WAIT, RD_HOLD} state_t;

   state_t           state;
   logic [15:0]      cnt;
   logic [1:0]       bank_q;
   redundant_poly_L3 conv;
   logic             wr_acc, start_acc, rd_acc;
`ifdef PAIRING_LOADER_BCAST_EN
   logic [6:0]       wr_lo_q;
`endif

   always_comb begin
      conv = '0;
      for (int i = 0; i < ADD_DIV; i++) begin
         conv[i].val   = wr_data[i*FW +: FW];
         conv[i].carry = '0;
      end
   end

   // Priority in IDLE: write, then start, then read.
   assign wr_acc    = (state == IDLE) && wr_valid && wr_ready;
   assign start_acc = (state == IDLE) && start && !wr_valid;
   assign rd_acc    = (state == IDLE) && rd_req_valid && rd_req_ready && !wr_valid && !start;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state            <= IDLE;
         cnt              <= '0;
         bank_q           <= '0;
         wr_ready         <= 1'b0;
         rd_req_ready     <= 1'b0;
         done             <= 1'b0;
         err              <= 1'b0;
         rd_valid         <= 1'b0;
         rd_data          <= '0;
         core_extin_en    <= 1'b0;
         core_extin_addr  <= '0;
         core_extin_data  <= '0;
         core_run         <= 1'b0;
         core_swrst       <= 1'b0;
         core_n_func      <= '0;
         core_extout_addr <= '0;
`ifdef PAIRING_LOADER_BCAST_EN
         wr_lo_q          <= '0;
`endif
      end else begin
         done     <= 1'b0;
         core_run <= 1'b0;
         case (state)
            IDLE: begin
               if (wr_acc) begin
                  core_extin_en   <= 1'b1;
                  core_extin_data <= conv;
                  core_swrst      <= 1'b1;
                  wr_ready        <= 1'b0;
                  rd_req_ready    <= 1'b0;
                  state           <= WRITE;
`ifdef PAIRING_LOADER_BCAST_EN
                  core_extin_addr <= {2'd0, wr_addr[6:0]};
                  wr_lo_q         <= wr_addr[6:0];
                  bank_q          <= 2'd0;
`else
                  // Starting on the last bank makes WRITE a single cycle.
                  core_extin_addr <= wr_addr;
                  bank_q          <= 2'(N_BANK-1);
`endif
               end else if (start_acc) begin
                  core_n_func  <= func;
                  core_run     <= 1'b1;
                  core_swrst   <= 1'b0;
                  err          <= 1'b0;
                  cnt          <= '0;
                  wr_ready     <= 1'b0;
                  rd_req_ready <= 1'b0;
                  state        <= RUN_HI;
               end else if (rd_acc) begin
                  core_extout_addr <= rd_addr;
                  cnt              <= '0;
                  wr_ready         <= 1'b0;
                  rd_req_ready     <= 1'b0;
                  state            <= RD_WAIT;
               end else begin
                  wr_ready     <= 1'b1;
                  rd_req_ready <= !wr_valid && !start;
               end
            end
            WRITE: begin
               if (bank_q == 2'(N_BANK-1)) begin
                  core_extin_en <= 1'b0;
                  wr_ready      <= 1'b1;
                  rd_req_ready  <= !wr_valid && !start;
                  state         <= IDLE;
               end else begin
                  bank_q <= bank_q + 2'd1;
`ifdef PAIRING_LOADER_BCAST_EN
                  core_extin_addr <= {bank_q + 2'd1, wr_lo_q};
`endif
               end
            end
            RUN_HI: begin
               if (core_busy) begin
                  state <= RUN_LO;
               end else if (cnt == 16'(BUSY_TO-1)) begin
                  err          <= 1'b1;
                  done         <= 1'b1;
                  wr_ready     <= 1'b1;
                  rd_req_ready <= !wr_valid && !start;
                  state        <= IDLE;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            RUN_LO: begin
               if (!core_busy) begin
                  done         <= 1'b1;
                  wr_ready     <= 1'b1;
                  rd_req_ready <= !wr_valid && !start;
                  state        <= IDLE;
               end
            end
            RD_WAIT: begin
               // Address went out one cycle before RD_WAIT began; data settles RD_LAT cycles later.
               if (cnt == 16'(RD_LAT)) begin
                  rd_data  <= core_extout_data;
                  rd_valid <= 1'b1;
                  state    <= RD_HOLD;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            RD_HOLD: begin
               if (rd_ready) begin
                  rd_valid     <= 1'b0;
                  wr_ready     <= 1'b1;
                  rd_req_ready <= !wr_valid && !start;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pairing_host_loader.sv
// Directed bench for pairing_host_loader: reset, operand writes, run/timeout control and readback.
module tb_pairing_host_loader;
   import pairing_loader_pkg::*;

   localparam int VAL_W  = 320;
   localparam int RD_LAT = 4;
`ifdef PAIRING_LOADER_BCAST_EN
   localparam int NW = 4;
`else
   localparam int NW = 1;
`endif

   logic                 clk = 1'b0;
   logic                 rstn;
   logic                 wr_valid, wr_ready;
   logic [8:0]           wr_addr;
   logic [VAL_W-1:0]     wr_data;
   logic                 start;
   logic [3:0]           func;
   logic                 done, err;
   logic                 rd_req_valid, rd_req_ready;
   logic [8:0]           rd_addr;
   logic                 rd_valid, rd_ready;
   logic [288:0]         rd_data;
   logic                 core_extin_en;
   logic [8:0]           core_extin_addr;
   redundant_poly_L3     core_extin_data;
   logic                 core_run, core_swrst;
   logic [3:0]           core_n_func;
   logic [8:0]           core_extout_addr;
   logic                 core_busy;
   logic [288:0]         core_extout_data;

   int checks = 0;
   int fails  = 0;

   pairing_host_loader dut (
      .clk(clk), .rstn(rstn),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .func(func), .done(done), .err(err),
      .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_addr(rd_addr),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .core_extin_en(core_extin_en), .core_extin_addr(core_extin_addr),
      .core_extin_data(core_extin_data), .core_run(core_run), .core_swrst(core_swrst),
      .core_n_func(core_n_func), .core_extout_addr(core_extout_addr),
      .core_busy(core_busy), .core_extout_data(core_extout_data)
   );

   always #5 clk = ~clk;

   // Core read port model: data follows the address RD_LAT cycles later.
   logic [8:0] addr_pipe [RD_LAT];
   function automatic logic [288:0] model_word(input logic [8:0] a);
      return {a, {10{28'hABCDE00 ^ {19'd0, a}}}};
   endfunction
   always @(posedge clk) begin
      addr_pipe[0] <= core_extout_addr;
      for (int i = 1; i < RD_LAT; i++) addr_pipe[i] <= addr_pipe[i-1];
   end
   assign core_extout_data = model_word(addr_pipe[RD_LAT-1]);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [8:0]   exp_a [4];
      logic [8:0]   exp_a2;
      logic [319:0] d2;
      logic [351:0] e2;
      logic [288:0] w;
      int           n;

`ifdef PAIRING_LOADER_BCAST_EN
      exp_a  = '{9'h010, 9'h090, 9'h110, 9'h190};
      exp_a2 = 9'h07F;
`else
      exp_a  = '{9'h1A5, 9'h000, 9'h000, 9'h000};
      exp_a2 = 9'h0FF;
`endif
      d2 = {80'h0123456789ABCDEF0123, 80'hFEDCBA9876543210FEDC,
            80'h00000000000000000001, 80'h80000000000000000000};
      e2 = {8'h00, 80'h0123456789ABCDEF0123, 8'h00, 80'hFEDCBA9876543210FEDC,
            8'h00, 80'h00000000000000000001, 8'h00, 80'h80000000000000000000};

      rstn = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; func = '0;
      rd_req_valid = 1'b0; rd_addr = '0; rd_ready = 1'b0; core_busy = 1'b0;
      repeat (3) step();

      // Reset values
      chk("rst_wr_ready", wr_ready, 1'b0);
      chk("rst_rd_req_ready", rd_req_ready, 1'b0);
      chk("rst_done_err_rdvalid", {done, err, rd_valid}, 3'b000);
      chk("rst_rd_data", rd_data, '0);
      chk("rst_extin", {core_extin_en, core_extin_addr, core_extin_data}, '0);
      chk("rst_ctrl", {core_run, core_swrst, core_n_func, core_extout_addr}, '0);
      rstn = 1'b1;
      step();
      chk("wr_ready_after_rst", wr_ready, 1'b1);
      chk("rd_req_ready_after_rst", rd_req_ready, 1'b1);

      // Reset asserted while a write is in flight
      wr_addr = 9'h055; wr_data = 320'h5; wr_valid = 1'b1;
      step();
      wr_valid = 1'b0;
      chk("midwr_en", core_extin_en, 1'b1);
      rstn = 1'b0;
      #1;
      chk("midwr_rst_en", core_extin_en, 1'b0);
      chk("midwr_rst_addr_data", {core_extin_addr, core_extin_data}, '0);
      chk("midwr_rst_swrst", core_swrst, 1'b0);
      chk("midwr_rst_wr_ready", wr_ready, 1'b0);
      step();
      rstn = 1'b1;
      step();
      chk("midwr_release_wr_ready", wr_ready, 1'b1);

      // Operand write, limb0 = 1
      wr_addr = exp_a[0]; wr_data = 320'd1;
`ifdef PAIRING_LOADER_BCAST_EN
      wr_addr = 9'h010;
`endif
      wr_valid = 1'b1;
      step();
      wr_valid = 1'b0;
      for (int b = 0; b < NW; b++) begin
         chk("wr1_en", core_extin_en, 1'b1);
         chk("wr1_addr", core_extin_addr, exp_a[b]);
         chk("wr1_data", core_extin_data, 352'd1);
         chk("wr1_swrst", core_swrst, 1'b1);
         chk("wr1_ready_low", wr_ready, 1'b0);
         step();
      end
      chk("wr1_en_end", core_extin_en, 1'b0);
      chk("wr1_ready_back", wr_ready, 1'b1);

      // Limb mapping, and a simultaneous start that must lose to the write
      wr_addr = 9'h0FF; wr_data = d2; wr_valid = 1'b1; start = 1'b1; func = 4'd9;
      step();
      wr_valid = 1'b0; start = 1'b0;
      chk("wr2_addr", core_extin_addr, exp_a2);
      chk("wr2_data", core_extin_data, e2);
      chk("wr2_no_run", core_run, 1'b0);
      repeat (NW) step();
      chk("wr2_ready_back", wr_ready, 1'b1);
      chk("wr2_func_untaken", core_n_func, 4'd0);

      // Run: busy high for cycles 3..49, falls at 50, done expected at 51
      func = 4'd3; start = 1'b1;
      chk("run_swrst_before", core_swrst, 1'b1);
      step();
      start = 1'b0;
      for (int c = 1; c <= 53; c++) begin
         core_busy = (c >= 3 && c <= 49);
         start = (c == 10);
         func  = (c == 10) ? 4'd5 : 4'd3;
         chk("run_pulse", core_run, (c == 1));
         chk("run_done", done, (c == 51));
         chk("run_n_func", core_n_func, 4'd3);
         chk("run_swrst", core_swrst, 1'b0);
         step();
      end
      start = 1'b0;
      chk("run_err", err, 1'b0);

      // Timeout: busy never rises
      func = 4'd7; start = 1'b1; core_busy = 1'b0;
      step();
      start = 1'b0;
      chk("to_run", core_run, 1'b1);
      for (int c = 1; c <= 66; c++) begin
         chk("to_done", done, (c == 65));
         chk("to_err", err, (c >= 65));
         step();
      end
      func = 4'd2; start = 1'b1;
      step();
      start = 1'b0;
      chk("to_err_cleared", err, 1'b0);
      chk("to_n_func2", core_n_func, 4'd2);
      step();
      core_busy = 1'b1;
      step();
      core_busy = 1'b0;
      n = 0;
      while (!done && n < 20) begin
         step();
         n++;
      end
      chk("run2_done_seen", done, 1'b1);
      chk("run2_done_lat", n, 1);
      chk("run2_err", err, 1'b0);
      step();

      // Readback with rd_ready held low
      w = model_word(9'h010);
      rd_addr = 9'h010; rd_req_valid = 1'b1; rd_ready = 1'b0;
      chk("rd_req_ready_idle", rd_req_ready, 1'b1);
      step();
      rd_req_valid = 1'b0;
      chk("rd_extout_addr", core_extout_addr, 9'h010);
      chk("rd_req_ready_busy", rd_req_ready, 1'b0);
      repeat (4) step();
      chk("rd_valid_early", rd_valid, 1'b0);
      step();
      chk("rd_valid", rd_valid, 1'b1);
      chk("rd_data", rd_data, w);
      for (int k = 0; k < 5; k++) begin
         step();
         chk("rd_hold_valid", rd_valid, 1'b1);
         chk("rd_hold_data", rd_data, w);
      end
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
      chk("rd_released", rd_valid, 1'b0);
      chk("rd_data_kept", rd_data, w);
      chk("rd_req_ready_back", rd_req_ready, 1'b1);
      chk("rd_extout_addr_kept", core_extout_addr, 9'h010);

      // Second read, consumer always ready
      rd_addr = 9'h1FF; rd_req_valid = 1'b1; rd_ready = 1'b1;
      step();
      rd_req_valid = 1'b0;
      repeat (5) step();
      chk("rd2_valid", rd_valid, 1'b1);
      chk("rd2_data", rd_data, model_word(9'h1FF));
      step();
      chk("rd2_released", rd_valid, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
